// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and animation-state codes for the sprite compositor
package sprite_pkg;
    localparam logic [7:0] TRANSP_DEF = 8'hE3;
    localparam int SPR_W_DEF = 113;
    localparam int SPR_H_DEF = 157;
    typedef enum logic [3:0] {
        ST_IDLE, ST_WALK, ST_WALKBACK,
        ST_ATK_START, ST_ATK_MID, ST_ATK_PULL,
        ST_DIR_START, ST_DIR_MID, ST_DIR_PULL,
        ST_GOTHIT, ST_BLOCK
    } state_e;
endpackage

// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if: pixel stream, sprite attributes, ROM port and composited output
interface sprite_compositor_if #(
    parameter int NUM_SPR = 2,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 8,
    parameter int STATE_W = 4,
    parameter int ID_W    = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
);
    logic                       frame_start;
    logic                       pix_valid;
    logic [COORD_W-1:0]         pix_x, pix_y;
    logic [NUM_SPR-1:0]         spr_en, spr_flip;
    logic [NUM_SPR*COORD_W-1:0] spr_x, spr_y;
    logic [NUM_SPR*STATE_W-1:0] spr_state;
    logic [NUM_SPR*ADDR_W-1:0]  rom_addr;
    logic [NUM_SPR*STATE_W-1:0] rom_sel;
    logic [NUM_SPR*COLOR_W-1:0] rom_data;
    logic                       out_valid, out_visible;
    logic [COLOR_W-1:0]         out_color;
    logic [ID_W-1:0]            out_id;
    logic [NUM_SPR-1:0]         coll_live, coll_frame;
    modport slave (
        input  frame_start, pix_valid, pix_x, pix_y, spr_en, spr_flip, spr_x, spr_y, spr_state, rom_data,
        output rom_addr, rom_sel, out_valid, out_visible, out_color, out_id, coll_live, coll_frame
    );
    modport master (
        output frame_start, pix_valid, pix_x, pix_y, spr_en, spr_flip, spr_x, spr_y, spr_state, rom_data,
        input  rom_addr, rom_sel, out_valid, out_visible, out_color, out_id, coll_live, coll_frame
    );
endinterface

// File: rtl/sprite_channel.sv
// sprite_channel: per-sprite shadow registers, hit test and mirrored ROM address generation
module sprite_channel #(
    parameter int COORD_W = 10,
    parameter int SPR_W   = 113,
    parameter int SPR_H   = 157,
    parameter int ADDR_W  = 15,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               en_in,
    input  logic               flip_in,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [STATE_W-1:0] state_in,
    output logic               hit_q,
    output logic [ADDR_W-1:0]  addr_q,
    output logic [STATE_W-1:0] sel_q
);
    localparam int CW = COORD_W + 1;
    logic en_q, en_d, flip_q, flip_d, hit_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, rx, ry, col;
    logic [STATE_W-1:0] st_q, st_d, sel_d;
    logic [ADDR_W-1:0] addr_d;
    always_comb begin
        en_d   = frame_start ? en_in : en_q;
        flip_d = frame_start ? flip_in : flip_q;
        x_d    = frame_start ? x_in : x_q;
        y_d    = frame_start ? y_in : y_q;
        st_d   = frame_start ? state_in : st_q;
        // one extra bit keeps sprites near the right/bottom edge from wrapping to 0
        hit_d  = en_q & pix_valid
               & ({1'b0, pix_x} >= {1'b0, x_q}) & ({1'b0, pix_x} < {1'b0, x_q} + CW'(SPR_W))
               & ({1'b0, pix_y} >= {1'b0, y_q}) & ({1'b0, pix_y} < {1'b0, y_q} + CW'(SPR_H));
        rx     = pix_x - x_q;
        ry     = pix_y - y_q;
        col    = flip_q ? COORD_W'(SPR_W - 1) - rx : rx;
        addr_d = hit_d ? ADDR_W'(ry) * ADDR_W'(SPR_W) + ADDR_W'(col) : '0;
        sel_d  = st_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            en_q   <= 1'b0;
            flip_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            st_q   <= '0;
            hit_q  <= 1'b0;
            addr_q <= '0;
            sel_q  <= '0;
        end else begin
            en_q   <= en_d;
            flip_q <= flip_d;
            x_q    <= x_d;
            y_q    <= y_d;
            st_q   <= st_d;
            hit_q  <= hit_d;
            addr_q <= addr_d;
            sel_q  <= sel_d;
        end
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: 3-stage per-pixel sprite hit test, priority select and collision flags
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_SPR = 2,
    parameter int COORD_W = 10,
    parameter int SPR_W   = SPR_W_DEF,
    parameter int SPR_H   = SPR_H_DEF,
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 8,
    parameter int STATE_W = 4,
    parameter logic [COLOR_W-1:0] TRANSP = COLOR_W'(TRANSP_DEF)
) (
    input logic clk,
    input logic rst_n,
    sprite_compositor_if.slave bus
);
    localparam int ID_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    logic [NUM_SPR-1:0] hit0, hit1_q, hit1_d, opq, sets;
    logic [NUM_SPR*ADDR_W-1:0] addr0;
    logic [NUM_SPR*STATE_W-1:0] sel0, sel1_q, sel1_d;
    logic valid0_q, valid0_d, valid1_q, valid1_d, out_valid_q, out_valid_d, out_vis_q, out_vis_d;
    logic [COLOR_W-1:0] out_color_q, out_color_d;
    logic [ID_W-1:0] out_id_q, out_id_d, win;
    logic [NUM_SPR-1:0] coll_live_q, coll_live_d, coll_frame_q, coll_frame_d;
    for (genvar g = 0; g < NUM_SPR; g++) begin : g_ch
        sprite_channel #(
            .COORD_W(COORD_W), .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .STATE_W(STATE_W)
        ) u_ch (
            .clk(clk), .rst_n(rst_n), .frame_start(bus.frame_start), .pix_valid(bus.pix_valid),
            .pix_x(bus.pix_x), .pix_y(bus.pix_y),
            .en_in(bus.spr_en[g]), .flip_in(bus.spr_flip[g]),
            .x_in(bus.spr_x[g*COORD_W +: COORD_W]), .y_in(bus.spr_y[g*COORD_W +: COORD_W]),
            .state_in(bus.spr_state[g*STATE_W +: STATE_W]),
            .hit_q(hit0[g]), .addr_q(addr0[g*ADDR_W +: ADDR_W]), .sel_q(sel0[g*STATE_W +: STATE_W])
        );
    end
    assign bus.rom_addr    = addr0;
    assign bus.rom_sel     = sel0;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_visible = out_vis_q;
    assign bus.out_color   = out_color_q;
    assign bus.out_id      = out_id_q;
    assign bus.coll_live   = coll_live_q;
    assign bus.coll_frame  = coll_frame_q;
    always_comb begin
        valid0_d = bus.pix_valid;
        valid1_d = valid0_q;
        hit1_d   = hit0;
        sel1_d   = sel0;
        win      = '0;
        // frames above BLOCK are not populated in the ROM, so those channels never draw
        for (int i = 0; i < NUM_SPR; i++) begin
            opq[i] = hit1_q[i] & (bus.rom_data[i*COLOR_W +: COLOR_W] != TRANSP)
                   & (sel1_q[i*STATE_W +: STATE_W] <= STATE_W'(ST_BLOCK));
            if (opq[i]) win = ID_W'(i);
        end
        sets         = ((opq & (opq - 1'b1)) != '0) ? opq : '0;
        out_valid_d  = valid1_q;
        out_vis_d    = |opq;
        out_color_d  = out_vis_d ? bus.rom_data[win*COLOR_W +: COLOR_W] : TRANSP;
        out_id_d     = win;
        coll_live_d  = bus.frame_start ? '0 : coll_live_q | sets;
        coll_frame_d = bus.frame_start ? coll_live_q | sets : coll_frame_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid0_q     <= 1'b0;
            valid1_q     <= 1'b0;
            hit1_q       <= '0;
            sel1_q       <= '0;
            out_valid_q  <= 1'b0;
            out_vis_q    <= 1'b0;
            out_color_q  <= TRANSP;
            out_id_q     <= '0;
            coll_live_q  <= '0;
            coll_frame_q <= '0;
        end else begin
            valid0_q     <= valid0_d;
            valid1_q     <= valid1_d;
            hit1_q       <= hit1_d;
            sel1_q       <= sel1_d;
            out_valid_q  <= out_valid_d;
            out_vis_q    <= out_vis_d;
            out_color_q  <= out_color_d;
            out_id_q     <= out_id_d;
            coll_live_q  <= coll_live_d;
            coll_frame_q <= coll_frame_d;
        end
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed checks of addressing, priority, clipping, shadowing and collisions
module tb_sprite_compositor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ch1_tr = 1'b0;
    int checks = 0;
    int failures = 0;
    sprite_compositor_if #(.NUM_SPR(2)) bus ();
    sprite_compositor dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        bus.rom_data[7:0]  <= bus.rom_addr[7:0];
        bus.rom_data[15:8] <= ch1_tr ? 8'hE3 : bus.rom_addr[22:15];
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic fs();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
    endtask
    task automatic pix(input int x, input int y);
        bus.pix_valid = 1'b1;
        bus.pix_x = 10'(x);
        bus.pix_y = 10'(y);
        step();
        bus.pix_valid = 1'b0;
    endtask
    task automatic outs(input string tag, input logic vis, input logic [7:0] color, input logic id);
        step();
        step();
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_vis"}, 32'(bus.out_visible), 32'(vis));
        chk({tag, "_color"}, 32'(bus.out_color), 32'(color));
        chk({tag, "_id"}, 32'(bus.out_id), 32'(id));
    endtask
    initial begin
        bus.frame_start = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_x = '0;
        bus.pix_y = '0;
        bus.spr_en = 2'b01;
        bus.spr_flip = 2'b00;
        bus.spr_x = {10'd0, 10'd100};
        bus.spr_y = {10'd0, 10'd50};
        bus.spr_state = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_color", 32'(bus.out_color), 32'hE3);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_coll", 32'({bus.coll_live, bus.coll_frame}), 32'd0);
        rst_n = 1'b1;
        step();
        // shadows start disabled: no hit before the first frame_start
        pix(100, 50);
        outs("pre_fs", 1'b0, 8'hE3, 1'b0);
        fs();
        pix(100, 50);
        chk("a0_origin", 32'(bus.rom_addr[14:0]), 32'd0);
        outs("origin", 1'b1, 8'h00, 1'b0);
        pix(100, 51);
        chk("a0_row1", 32'(bus.rom_addr[14:0]), 32'd113);
        outs("row1", 1'b1, 8'h71, 1'b0);
        bus.spr_flip = 2'b01;
        fs();
        pix(100, 51);
        chk("a0_flip", 32'(bus.rom_addr[14:0]), 32'd225);
        outs("flip", 1'b1, 8'hE1, 1'b0);
        bus.spr_x = {10'd0, 10'd300};
        pix(100, 51);
        chk("a0_shadow", 32'(bus.rom_addr[14:0]), 32'd225);
        outs("shadow", 1'b1, 8'hE1, 1'b0);
        fs();
        pix(100, 51);
        chk("a0_moved", 32'(bus.rom_addr[14:0]), 32'd0);
        outs("moved", 1'b0, 8'hE3, 1'b0);
        bus.spr_en = 2'b11;
        bus.spr_flip = 2'b00;
        bus.spr_x = {10'd200, 10'd200};
        bus.spr_y = {10'd100, 10'd100};
        fs();
        pix(205, 103);
        chk("a1_coll", 32'(bus.rom_addr[29:15]), 32'd344);
        outs("coll", 1'b1, 8'h58, 1'b1);
        chk("coll_live", 32'(bus.coll_live), 32'd3);
        fs();
        chk("coll_frame", 32'(bus.coll_frame), 32'd3);
        chk("coll_clr", 32'(bus.coll_live), 32'd0);
        ch1_tr = 1'b1;
        pix(205, 103);
        outs("transp1", 1'b1, 8'h58, 1'b0);
        chk("coll_none", 32'(bus.coll_live), 32'd0);
        ch1_tr = 1'b0;
        bus.spr_en = 2'b01;
        bus.spr_x = {10'd0, 10'd950};
        bus.spr_y = {10'd0, 10'd50};
        fs();
        pix(1020, 50);
        chk("a0_edge", 32'(bus.rom_addr[14:0]), 32'd70);
        outs("edge", 1'b1, 8'h46, 1'b0);
        pix(10, 50);
        outs("nowrap", 1'b0, 8'hE3, 1'b0);
        bus.spr_state = {4'd0, 4'd11};
        fs();
        pix(1020, 50);
        chk("sel_bad", 32'(bus.rom_sel[3:0]), 32'd11);
        outs("bad_state", 1'b0, 8'hE3, 1'b0);
        bus.spr_state = '0;
        bus.spr_en = 2'b11;
        bus.spr_x = {10'd200, 10'd200};
        bus.spr_y = {10'd100, 10'd100};
        fs();
        pix(205, 103);
        outs("pre_rst", 1'b1, 8'h58, 1'b1);
        chk("pre_rst_coll", 32'(bus.coll_live), 32'd3);
        pix(205, 103);
        rst_n = 1'b0;
        #1;
        chk("mrst_addr", 32'(bus.rom_addr), 32'd0);
        chk("mrst_coll", 32'(bus.coll_live), 32'd0);
        chk("mrst_color", 32'(bus.out_color), 32'hE3);
        chk("mrst_vis", 32'(bus.out_visible), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        pix(205, 103);
        outs("post_rst", 1'b0, 8'hE3, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
